// File: rtl/l1_trigger_collector_if.sv
// Event stream between the trigger collector and the readout/TURF link logic.
// Carries {beam mask, timestamp} with a valid/ready handshake.
interface l1_trigger_collector_if #(
    parameter int unsigned NBEAMS    = 2,
    parameter int unsigned TIME_BITS = 32
);
    logic [NBEAMS+TIME_BITS-1:0] evt_tdata;
    logic                        evt_tvalid;
    logic                        evt_tready;

    modport master (output evt_tdata, output evt_tvalid, input evt_tready);
    modport slave  (input evt_tdata, input evt_tvalid, output evt_tready);
endinterface

// File: rtl/l1_trigger_collector.sv
// Merges per-beam L1 triggers inside a coincidence window into timestamped
// events, queues them in a first-word-fall-through FIFO and counts drops.
module l1_trigger_collector #(
    parameter int unsigned NBEAMS        = 2,
    parameter int unsigned WINDOW_CLOCKS = 8,
    parameter int unsigned TIME_BITS     = 32,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                   aclk,
    input  logic                   reset_i,
    input  logic [NBEAMS-1:0]      trigger_i,
    input  logic                   enable_i,
    l1_trigger_collector_if.master evt,
    output logic                   busy_o,
    output logic [31:0]            evt_count_o,
    output logic [15:0]            drop_count_o
);
    localparam int unsigned DW = NBEAMS + TIME_BITS;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (WINDOW_CLOCKS > 1) ? $clog2(WINDOW_CLOCKS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WINDOW_CLOCKS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

    state_t                 state_q;
    logic [TIME_BITS-1:0]   ts_q;
    logic [TIME_BITS-1:0]   ev_ts_q;
    logic [NBEAMS-1:0]      mask_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;

    logic [DW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   valid_q;
    logic [DW-1:0]          head_q;
    logic [31:0]            evt_cnt_q;
    logic [15:0]            drop_cnt_q;

    logic                   push_c;
    logic                   pop_c;
    logic [AW-1:0]          rd_next_c;
    logic [AW:0]            count_next_c;
    logic [DW-1:0]          wdata_c;
    logic [DW-1:0]          head_next_c;

    // Full is judged on occupancy at the start of PUSH; a same-cycle pop does not help.
    always_comb begin
        push_c       = (state_q == PUSH) && (count_q != FULL_CNT);
        pop_c        = valid_q && evt.evt_tready;
        rd_next_c    = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_next_c = count_q + (AW + 1)'(push_c) - (AW + 1)'(pop_c);
        wdata_c      = {mask_q, ev_ts_q};
        // Incoming word becomes the head when it lands in the slot the read pointer moves to.
        head_next_c  = (push_c && (wr_ptr_q == rd_next_c)) ? wdata_c : mem_q[rd_next_c];
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TIME_BITS'(1);
        end
    end

    // Coincidence-window FSM.
    always_ff @(posedge aclk) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ev_ts_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && (|trigger_i)) begin
                        mask_q  <= trigger_i;
                        ev_ts_q <= ts_q;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= (CNT_INIT != '0) ? COLLECT : PUSH;
                    end
                end
                COLLECT: begin
                    mask_q <= mask_q | trigger_i;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= PUSH;
                    end
                end
                PUSH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wdata_c;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_next_c;
            count_q  <= count_next_c;
            valid_q  <= (count_next_c != '0);
            head_q   <= head_next_c;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            evt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push_c) begin
                evt_cnt_q <= evt_cnt_q + 32'd1;
            end
            if ((state_q == PUSH) && !push_c && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign evt.evt_tdata  = head_q;
    assign evt.evt_tvalid = valid_q;
    assign busy_o         = busy_q;
    assign evt_count_o    = evt_cnt_q;
    assign drop_count_o   = drop_cnt_q;
endmodule

// File: tb/tb_l1_trigger_collector.sv
// Self-checking bench for l1_trigger_collector: table-driven trigger patterns,
// scoreboarded event stream, and hand sequences for FIFO-full, reset, enable and wrap.
module tb_l1_trigger_collector;
    logic        aclk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [1:0]  trigger_i;
    logic [1:0]  trig2;
    logic        busy, busy2;
    logic [31:0] evt_count, evt_count2;
    logic [15:0] drop_count, drop_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_ready = 1'b0;

    logic [33:0] q[$];
    logic [5:0]  q2[$];

    typedef struct {
        int         at;
        logic [1:0] trig;
        bit         opens;
        logic [1:0] mask;
    } vec_t;
    vec_t tbl[11];

    always #5 aclk = ~aclk;

    l1_trigger_collector_if #(.NBEAMS(2), .TIME_BITS(32)) ev();
    l1_trigger_collector_if #(.NBEAMS(2), .TIME_BITS(4))  ev2();

    l1_trigger_collector #(.NBEAMS(2), .WINDOW_CLOCKS(8), .TIME_BITS(32), .FIFO_DEPTH(4)) dut (
        .aclk(aclk), .reset_i(reset_i), .trigger_i(trigger_i), .enable_i(enable_i),
        .evt(ev.master), .busy_o(busy), .evt_count_o(evt_count), .drop_count_o(drop_count)
    );

    l1_trigger_collector #(.NBEAMS(2), .WINDOW_CLOCKS(8), .TIME_BITS(4), .FIFO_DEPTH(4)) dut_wrap (
        .aclk(aclk), .reset_i(reset_i), .trigger_i(trig2), .enable_i(enable_i),
        .evt(ev2.master), .busy_o(busy2), .evt_count_o(evt_count2), .drop_count_o(drop_count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: compare each accepted beat against the oldest expected event.
    task automatic mon();
        if (ev.evt_tvalid && ev.evt_tready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_evt at cycle %0d: got %0h expected none", cyc, ev.evt_tdata);
            end else begin
                chk("evt_tdata", 64'(ev.evt_tdata), 64'(q.pop_front()));
            end
        end
        if (ev2.evt_tvalid && ev2.evt_tready) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_evt2 at cycle %0d: got %0h expected none", cyc, ev2.evt_tdata);
            end else begin
                chk("evt2_tdata", 64'(ev2.evt_tdata), 64'(q2.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        if (!reset_i) mon();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c, input bit chk_head);
        while (cyc < c) begin
            if (rnd_ready) ev.evt_tready = 1'($urandom_range(0, 1));
            tick();
            if (chk_head && cyc >= 14) begin
                chk("stall_valid", 64'(ev.evt_tvalid), 64'd1);
                chk("stall_head", 64'(ev.evt_tdata), 64'(q[0]));
            end
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        cyc = 0;
        q.delete();
        q2.delete();
    endtask

    task automatic drain();
        ev.evt_tready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        chk("drain_left", 64'(q.size()), 64'd0);
        tick();
        chk("drain_valid", 64'(ev.evt_tvalid), 64'd0);
    endtask

    initial begin
        reset_i = 1'b1;
        enable_i = 1'b1;
        trigger_i = 2'b00;
        trig2 = 2'b00;
        ev.evt_tready = 1'b0;
        ev2.evt_tready = 1'b1;

        tbl[0]  = '{10, 2'b01, 1'b1, 2'b11};
        tbl[1]  = '{17, 2'b10, 1'b0, 2'b00};
        tbl[2]  = '{18, 2'b10, 1'b0, 2'b00};
        tbl[3]  = '{19, 2'b10, 1'b1, 2'b10};
        tbl[4]  = '{30, 2'b11, 1'b1, 2'b11};
        tbl[5]  = '{40, 2'b10, 1'b1, 2'b11};
        tbl[6]  = '{41, 2'b01, 1'b0, 2'b00};
        tbl[7]  = '{48, 2'b01, 1'b0, 2'b00};
        tbl[8]  = '{49, 2'b01, 1'b1, 2'b01};
        tbl[9]  = '{58, 2'b00, 1'b0, 2'b00};
        tbl[10] = '{60, 2'b10, 1'b1, 2'b10};

        // Reset state and single trigger.
        do_reset();
        chk("rst_valid", 64'(ev.evt_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_evt_count", 64'(evt_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        run_to(10, 1'b0);
        trigger_i = 2'b01;
        q.push_back({2'b01, 32'd10});
        tick();
        trigger_i = 2'b00;
        chk("busy_collect", 64'(busy), 64'd1);
        run_to(18, 1'b0);
        chk("valid_before", 64'(ev.evt_tvalid), 64'd0);
        tick();
        chk("valid_rise", 64'(ev.evt_tvalid), 64'd1);
        chk("single_tdata", 64'(ev.evt_tdata), 64'({2'b01, 32'd10}));
        chk("single_count", 64'(evt_count), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
        drain();

        // Table: merge, dead time, retrigger and mixed patterns with random backpressure.
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_to(tbl[i].at, 1'b0);
            trigger_i = tbl[i].trig;
            if (tbl[i].opens) q.push_back({tbl[i].mask, 32'(tbl[i].at)});
            tick();
            trigger_i = 2'b00;
        end
        rnd_ready = 1'b0;
        drain();
        chk("tbl_evt_count", 64'(evt_count), 64'd6);
        chk("tbl_drop_count", 64'(drop_count), 64'd0);

        // Full FIFO: six events while stalled, then a pop coinciding with PUSH.
        do_reset();
        ev.evt_tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            run_to(5 + 10 * k, 1'b1);
            trigger_i = (k % 2 == 1) ? 2'b10 : 2'b01;
            if (k < 4) q.push_back({trigger_i, 32'(5 + 10 * k)});
            tick();
            trigger_i = 2'b00;
        end
        run_to(70, 1'b1);
        chk("full_evt_count", 64'(evt_count), 64'd4);
        chk("full_drop_count", 64'(drop_count), 64'd2);
        run_to(75, 1'b1);
        trigger_i = 2'b11;
        tick();
        trigger_i = 2'b00;
        run_to(83, 1'b1);
        ev.evt_tready = 1'b1;
        tick();
        ev.evt_tready = 1'b0;
        chk("pop_push_drop", 64'(drop_count), 64'd3);
        chk("pop_push_count", 64'(evt_count), 64'd4);
        drain();

        // Reset mid-window discards the open event.
        run_to(cyc + 2, 1'b0);
        trigger_i = 2'b01;
        tick();
        trigger_i = 2'b00;
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        cyc = 0;
        run_to(15, 1'b0);
        chk("midrst_valid", 64'(ev.evt_tvalid), 64'd0);
        chk("midrst_evt_count", 64'(evt_count), 64'd0);
        chk("midrst_drop_count", 64'(drop_count), 64'd0);

        // Enable gating, then enable dropped inside an open window.
        enable_i = 1'b0;
        run_to(20, 1'b0);
        trigger_i = 2'b11;
        tick();
        tick();
        trigger_i = 2'b00;
        run_to(40, 1'b0);
        chk("disabled_valid", 64'(ev.evt_tvalid), 64'd0);
        chk("disabled_count", 64'(evt_count), 64'd0);
        chk("disabled_busy", 64'(busy), 64'd0);
        enable_i = 1'b1;
        run_to(45, 1'b0);
        trigger_i = 2'b01;
        q.push_back({2'b11, 32'd45});
        tick();
        trigger_i = 2'b00;
        run_to(47, 1'b0);
        enable_i = 1'b0;
        run_to(49, 1'b0);
        trigger_i = 2'b10;
        tick();
        trigger_i = 2'b00;
        ev.evt_tready = 1'b1;
        run_to(60, 1'b0);
        chk("en_drop_count", 64'(evt_count), 64'd1);
        chk("en_drop_left", 64'(q.size()), 64'd0);
        enable_i = 1'b1;

        // Timestamp wrap on the 4-bit instance.
        do_reset();
        run_to(15, 1'b0);
        trig2 = 2'b01;
        q2.push_back({2'b01, 4'd15});
        tick();
        trig2 = 2'b00;
        run_to(31, 1'b0);
        trig2 = 2'b10;
        q2.push_back({2'b10, 4'd15});
        tick();
        trig2 = 2'b00;
        run_to(45, 1'b0);
        chk("wrap_left", 64'(q2.size()), 64'd0);
        chk("wrap_count", 64'(evt_count2), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/l1_trigger_collector.md
# l1_trigger_collector

Downstream of the L1 beamformed trigger stage in the `aclk` domain. Takes the per-beam `trigger_o` bits, merges beams firing within a short coincidence window into one event, and stamps the event with a free-running timestamp. Events are queued in a small FIFO and presented on a valid/ready stream to the readout/TURF link logic. It also counts accepted and dropped events.

## Interface
Parameters:
- `NBEAMS`, 2: number of beam trigger inputs.
- `WINDOW_CLOCKS`, 8: coincidence window length in `aclk` cycles. Must be ≥1.
- `TIME_BITS`, 32: timestamp width.
- `FIFO_DEPTH`, 16: event FIFO entries. Must be a power of 2 and ≥2.

Ports:
- `aclk`, in, 1: the only clock.
- `reset_i`, in, 1: reset, synchronous to `aclk`, active-high.
- `trigger_i`, in, NBEAMS: per-beam trigger bits (from `trigger_o`).
- `enable_i`, in, 1: permits new events to open.
- `evt_tdata`, out, NBEAMS+TIME_BITS: {beam mask, timestamp}; timestamp in the LSBs.
- `evt_tvalid`, out, 1: FIFO not empty.
- `evt_tready`, in, 1: consumer accept.
- `busy_o`, out, 1: high when the FSM is not IDLE.
- `evt_count_o`, out, 32: number of events written to the FIFO; wraps.
- `drop_count_o`, out, 16: number of events lost to a full FIFO; saturates at 0xFFFF.

## Operation
- Timestamp counter:
  - Free-running TIME_BITS counter, +1 every `aclk`.
  - Wraps 2^TIME_BITS−1 → 0.
- FSM states: IDLE, COLLECT, PUSH.
- IDLE:
  - When `enable_i && |trigger_i`: mask ← `trigger_i`, ts ← current timestamp, cnt ← WINDOW_CLOCKS−1.
  - Next state: COLLECT if cnt>0, else PUSH.
- COLLECT:
  - Each cycle: mask ← mask | `trigger_i`, cnt ← cnt−1.
  - When cnt==1: go to PUSH.
  - `enable_i` is ignored, so an open window always completes.
- PUSH:
  - If FIFO not full: write {mask, ts}, `evt_count_o`+1.
  - Otherwise: `drop_count_o`+1 (saturating).
  - Always return to IDLE.
  - `trigger_i` is ignored in PUSH, giving 1 cycle of dead time.
- Full test uses the occupancy at the start of the PUSH cycle. A pop in the same cycle does not rescue the push; the event is dropped.
- FIFO:
  - First-word-fall-through: `evt_tdata` is the head entry whenever `evt_tvalid`=1.
  - Pop on `evt_tvalid && evt_tready`.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
- `evt_tdata` must stay stable while `evt_tvalid && !evt_tready`.
- Reset effects:
  - Timestamp=0, FSM→IDLE, mask=0, FIFO emptied, both counters=0.
  - `evt_tvalid`=0, `busy_o`=0.
  - `evt_tdata` contents don't-care while invalid.
- Reset mid-window or mid-PUSH discards the open event and does not count it.

## Timing
- Trigger seen in IDLE at cycle T:
  - ts = timestamp value at T.
  - COLLECT occupies T+1 … T+WINDOW_CLOCKS−1.
  - PUSH occurs at T+WINDOW_CLOCKS.
  - `evt_tvalid` rises at T+WINDOW_CLOCKS+1 if the FIFO was empty.
- Minimum spacing between event starts: WINDOW_CLOCKS+1 cycles.
- Counters update in the cycle after PUSH. All outputs are registered.

## Test plan
- **Single trigger.** With WINDOW_CLOCKS=8, reset then release at cycle 0, `trigger_i`=2'b01 at cycle 10 → one event {2'b01, ts=10}; `evt_tvalid` rises at cycle 19; `evt_count_o`=1.
- **Beam merge.** Beam0 at cycle 10, beam1 at cycle 17 → one event with mask 2'b11, ts=10.
- **Dead time and retrigger.** Beam1 at 18 → ignored (PUSH cycle). Beam1 at 19 → second event, ts=19.
- **Full FIFO.**
  - Setup: FIFO_DEPTH=4, `evt_tready`=0, 6 events.
  - While stalled: 4 queued, `drop_count_o`=2, `evt_count_o`=4, head `evt_tdata` stable throughout.
  - Then raise `evt_tready` → 4 entries drain in order, after which `evt_tvalid`=0.
  - Separately, a pop coinciding with PUSH on a full FIFO still counts a drop.
- **Reset mid-window and enable gating.**
  - Assert `reset_i` at T+3 of a window → no event, counters 0.
  - With `enable_i`=0 and triggers present → no event.
  - Drop `enable_i` at T+2 → the open event is still pushed.
- **Timestamp wrap.** With TIME_BITS=4, triggers at timestamp 15 then 16 cycles later → ts fields 15 and 15, showing the counter wrapped.
